// File: rtl/wb_scheduler_pkg.sv
// Shared types for the write-back scheduler: requester identity and
// register-index width.
package wb_pkg;
    localparam int XLEN  = 32;
    localparam int RBITS = 5;

    typedef enum logic {WB_ALU = 1'b0, WB_LSU = 1'b1} wb_src_t;

    typedef logic [RBITS-1:0] reg_idx_t;
endpackage

// File: rtl/wb_scheduler_chk.sv
// Protocol checks for the write-back scheduler.
// x0 writes are excluded from the busy check because x0 is never marked busy.
module wb_scheduler_chk #(
    parameter int RBITS = 5
) (
    input logic                  clk,
    input logic                  rst,
    input logic                  acc,
    input logic [RBITS-1:0]      acc_rd,
    input logic [2**RBITS-1:0]   busy,
    input logic                  alu_ready,
    input logic                  lsu_ready
);
    a_acc_busy: assert property (@(posedge clk) disable iff (!rst)
        (acc && (acc_rd != '0)) |-> busy[acc_rd]);

    a_one_grant: assert property (@(posedge clk) disable iff (!rst)
        !(alu_ready && lsu_ready));
endmodule

// File: rtl/wb_scheduler_rr_arb2.sv
// Two-way round-robin arbiter.
// On contention the requester that lost the previous contended cycle wins.
module rr_arb2
    import wb_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    output logic [1:0] gnt
);
    wb_src_t last_r;
    logic    alu_wins_s;

    // grant selection
    always_comb begin
        alu_wins_s = 1'b0;
        gnt        = 2'b00;
        if (req == 2'b11) begin
            alu_wins_s = (last_r == WB_LSU);
            gnt        = alu_wins_s ? 2'b01 : 2'b10;
        end else begin
            gnt = req;
        end
    end

    // last-winner flop, updated only on contended cycles
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            last_r <= WB_LSU;
        end else if (req == 2'b11) begin
            last_r <= alu_wins_s ? WB_ALU : WB_LSU;
        end else begin
            last_r <= last_r;
        end
    end
endmodule

// File: rtl/wb_scheduler.sv
// Write-back scheduler: arbitrates the register file's single write port between
// the ALU and the LSU, and keeps the busy scoreboard that drives issue stalls.
module wb_scheduler #(
    parameter int XLEN  = wb_pkg::XLEN,
    parameter int RBITS = wb_pkg::RBITS
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             alu_valid,
    input  logic [RBITS-1:0] alu_rd,
    input  logic [XLEN-1:0]  alu_data,
    output logic             alu_ready,
    input  logic             lsu_valid,
    input  logic [RBITS-1:0] lsu_rd,
    input  logic [XLEN-1:0]  lsu_data,
    output logic             lsu_ready,
    input  logic             iss_valid,
    input  logic [RBITS-1:0] iss_rs1,
    input  logic [RBITS-1:0] iss_rs2,
    input  logic [RBITS-1:0] iss_rd,
    input  logic             iss_wr,
    output logic             iss_stall,
    output logic             w_en,
    output logic [RBITS-1:0] w_addr,
    output logic [XLEN-1:0]  w_data
);
    import wb_pkg::*;

    localparam int NREG = 2**RBITS;
    localparam logic [NREG-1:0] ONE_HOT0 = {{(NREG-1){1'b0}}, 1'b1};
    localparam logic [NREG-1:0] X0_MASK  = {{(NREG-1){1'b1}}, 1'b0};

    logic [1:0]       req_s;
    logic [1:0]       gnt_s;
    wb_src_t          acc_src_s;
    logic             acc_s;
    logic [RBITS-1:0] acc_rd_s;
    logic [XLEN-1:0]  acc_data_s;
    logic [NREG-1:0]  busy_r;
    logic [NREG-1:0]  clr_s;
    logic [NREG-1:0]  set_s;
    logic [NREG-1:0]  eff_busy_s;
    logic             stall_s;
    logic             w_en_r;
    logic [RBITS-1:0] w_addr_r;
    logic [XLEN-1:0]  w_data_r;

    // Requests are masked during reset so the readys read 0 while rst is low.
    assign req_s = {lsu_valid, alu_valid} & {rst, rst};

    rr_arb2 u_arb (
        .clk (clk),
        .rst (rst),
        .req (req_s),
        .gnt (gnt_s)
    );

    assign alu_ready = gnt_s[0];
    assign lsu_ready = gnt_s[1];
    assign acc_s     = gnt_s[0] | gnt_s[1];
    assign acc_src_s = gnt_s[1] ? WB_LSU : WB_ALU;

    // steer the accepted request onto the commit path
    always_comb begin
        acc_rd_s   = alu_rd;
        acc_data_s = alu_data;
        case (acc_src_s)
            WB_ALU: begin
                acc_rd_s   = alu_rd;
                acc_data_s = alu_data;
            end
            WB_LSU: begin
                acc_rd_s   = lsu_rd;
                acc_data_s = lsu_data;
            end
            default: begin
                acc_rd_s   = alu_rd;
                acc_data_s = alu_data;
            end
        endcase
    end

    // scoreboard release/set vectors and the issue stall
    always_comb begin
        clr_s   = '0;
        set_s   = '0;
        stall_s = 1'b0;
        if (acc_s) begin
            clr_s = ONE_HOT0 << acc_rd_s;
        end else begin
            clr_s = '0;
        end
        // The accepted index is released in the same cycle; the file forwards data.
        eff_busy_s = busy_r & ~clr_s;
        if (rst && iss_valid) begin
            stall_s = eff_busy_s[iss_rs1] | eff_busy_s[iss_rs2] | (iss_wr & eff_busy_s[iss_rd]);
        end else begin
            stall_s = 1'b0;
        end
        if (rst && iss_valid && iss_wr && !stall_s && (iss_rd != '0)) begin
            set_s = ONE_HOT0 << iss_rd;
        end else begin
            set_s = '0;
        end
    end

    assign iss_stall = stall_s;

    // busy bits; set beats clear, bit 0 is held at zero
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            busy_r <= '0;
        end else begin
            busy_r <= ((busy_r & ~clr_s) | set_s) & X0_MASK;
        end
    end

    // one-cycle write pulse to the register file
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            w_en_r   <= 1'b0;
            w_addr_r <= '0;
            w_data_r <= '0;
        end else if (acc_s) begin
            w_en_r   <= (acc_rd_s != '0);
            w_addr_r <= acc_rd_s;
            w_data_r <= acc_data_s;
        end else begin
            w_en_r   <= 1'b0;
            w_addr_r <= w_addr_r;
            w_data_r <= w_data_r;
        end
    end

    assign w_en   = w_en_r;
    assign w_addr = w_addr_r;
    assign w_data = w_data_r;

    wb_scheduler_chk #(.RBITS(RBITS)) u_chk (
        .clk       (clk),
        .rst       (rst),
        .acc       (acc_s),
        .acc_rd    (acc_rd_s),
        .busy      (busy_r),
        .alu_ready (alu_ready),
        .lsu_ready (lsu_ready)
    );
endmodule

// File: tb/tb_wb_scheduler.sv
// Randomized scoreboard bench for wb_scheduler against a behavioural model of
// arbitration, scoreboard and stall rules.
module tb_wb_scheduler;
    localparam int XLEN  = 32;
    localparam int RBITS = 5;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             alu_valid = 1'b0, lsu_valid = 1'b0, iss_valid = 1'b0, iss_wr = 1'b0;
    logic [RBITS-1:0] alu_rd = '0, lsu_rd = '0, iss_rs1 = '0, iss_rs2 = '0, iss_rd = '0;
    logic [XLEN-1:0]  alu_data = '0, lsu_data = '0;
    logic             alu_ready, lsu_ready, iss_stall, w_en;
    logic [RBITS-1:0] w_addr;
    logic [XLEN-1:0]  w_data;

    wb_scheduler #(.XLEN(XLEN), .RBITS(RBITS)) dut (
        .clk(clk), .rst(rst),
        .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data), .alu_ready(alu_ready),
        .lsu_valid(lsu_valid), .lsu_rd(lsu_rd), .lsu_data(lsu_data), .lsu_ready(lsu_ready),
        .iss_valid(iss_valid), .iss_rs1(iss_rs1), .iss_rs2(iss_rs2), .iss_rd(iss_rd),
        .iss_wr(iss_wr), .iss_stall(iss_stall),
        .w_en(w_en), .w_addr(w_addr), .w_data(w_data)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    logic [RBITS+XLEN-1:0] exp_q[$];

    // reference model state: which registers await a write, who lost last contention
    bit m_busy[32];
    bit m_lsu_won_last;
    bit m_alu_acc, m_lsu_acc;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h", nm, act, exp);
        end
    endtask

    task automatic model_reset();
        foreach (m_busy[i]) m_busy[i] = 1'b0;
        m_lsu_won_last = 1'b1;
        m_alu_acc = 1'b0;
        m_lsu_acc = 1'b0;
    endtask

    // One cycle: inputs already set at the negedge; check combinational outputs,
    // predict the write, advance the model, then wait for the next negedge.
    task automatic step();
        bit e_alu, e_lsu, e_stall;
        logic [4:0] rd;
        logic [31:0] d;
        bit eff[32];
        #1;
        if (!rst) begin
            chk("ready_in_reset", {alu_ready, lsu_ready}, 64'd0);
            chk("stall_in_reset", iss_stall, 64'd0);
            chk("wen_in_reset", w_en, 64'd0);
            model_reset();
        end else begin
            if (alu_valid && lsu_valid) begin
                e_alu = m_lsu_won_last;
                e_lsu = !e_alu;
                m_lsu_won_last = e_lsu;
            end else begin
                e_alu = alu_valid;
                e_lsu = lsu_valid;
            end
            rd = e_lsu ? lsu_rd : alu_rd;
            d  = e_lsu ? lsu_data : alu_data;
            eff = m_busy;
            if (e_alu || e_lsu) eff[rd] = 1'b0;
            e_stall = iss_valid && (eff[iss_rs1] || eff[iss_rs2] || (iss_wr && eff[iss_rd]));
            chk("alu_ready", alu_ready, 64'(e_alu));
            chk("lsu_ready", lsu_ready, 64'(e_lsu));
            chk("iss_stall", iss_stall, 64'(e_stall));
            if ((e_alu || e_lsu) && rd != 5'd0) exp_q.push_back({rd, d});
            m_busy = eff;
            if (iss_valid && iss_wr && !e_stall && iss_rd != 5'd0) m_busy[iss_rd] = 1'b1;
            m_alu_acc = e_alu;
            m_lsu_acc = e_lsu;
        end
        @(negedge clk);
    endtask

    // monitor: every write must match the oldest prediction, one cycle after acceptance
    always @(negedge clk) begin
        logic [RBITS+XLEN-1:0] e;
        if (w_en === 1'b1) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_write got addr=%0d data=%0h want none", w_addr, w_data);
            end else begin
                e = exp_q.pop_front();
                chk("write", {w_addr, w_data}, 64'(e));
            end
        end
        if (exp_q.size() != 0) begin
            total++;
            bad++;
            $display("FAIL missing_write got w_en=%0b want addr=%0d", w_en, exp_q[0][RBITS+XLEN-1:XLEN]);
            exp_q.delete();
        end
    end

    task automatic set_idle();
        alu_valid = 1'b0; lsu_valid = 1'b0;
        iss_valid = 1'b0; iss_wr = 1'b0;
        iss_rs1 = '0; iss_rs2 = '0; iss_rd = '0;
    endtask

    task automatic set_issue(input logic [4:0] rd);
        iss_valid = 1'b1; iss_wr = 1'b1; iss_rd = rd; iss_rs1 = '0; iss_rs2 = '0;
    endtask

    function automatic logic [4:0] pick_rd(input logic [4:0] other, input logic other_held);
        int r;
        for (int t = 0; t < 16; t++) begin
            r = $urandom_range(31, 1);
            if (m_busy[r] && !(other_held && other == r[4:0])) return r[4:0];
        end
        return 5'd0;
    endfunction

    initial begin
        model_reset();
        // reset with both requesters valid, then release: ALU wins first
        alu_valid = 1'b1; alu_rd = 5'd0; alu_data = 32'hDEADBEEF;
        lsu_valid = 1'b1; lsu_rd = 5'd0; lsu_data = 32'h1234_5678;
        iss_valid = 1'b1; iss_rs1 = 5'd5;
        @(negedge clk);
        step();
        step();
        rst = 1'b1;
        iss_valid = 1'b0;
        step();
        chk("x0_no_write", w_en, 64'd0);
        step();
        set_idle();

        // contention: alternate grants, re-issuing the register just released
        set_issue(5'd3); step();
        set_issue(5'd4); step();
        alu_valid = 1'b1; alu_rd = 5'd3; alu_data = $urandom;
        lsu_valid = 1'b1; lsu_rd = 5'd4; lsu_data = $urandom;
        for (int k = 0; k < 4; k++) begin
            set_issue((k % 2 == 0) ? 5'd3 : 5'd4);
            step();
        end
        set_idle();

        // RAW stall, then same-cycle release
        set_issue(5'd5); step();
        iss_valid = 1'b1; iss_wr = 1'b0; iss_rs1 = 5'd5; iss_rd = '0;
        step();
        alu_valid = 1'b1; alu_rd = 5'd5; alu_data = $urandom;
        step();
        set_idle();

        // set wins over clear on the same index
        set_issue(5'd7); step();
        lsu_valid = 1'b1; lsu_rd = 5'd7; lsu_data = $urandom;
        set_issue(5'd7); step();
        set_idle();
        iss_valid = 1'b1; iss_rs1 = 5'd7;
        step();
        set_idle();

        // reset while a write is on the port and busy[9] is pending
        set_issue(5'd9); step();
        set_issue(5'd10); step();
        set_idle();
        alu_valid = 1'b1; alu_rd = 5'd10; alu_data = $urandom;
        step();
        set_idle();
        #1;
        chk("wen_before_reset", {w_en, w_addr}, {58'd0, 1'b1, 5'd10});
        rst = 1'b0;
        #1;
        chk("wen_async_reset", w_en, 64'd0);
        exp_q.delete();
        model_reset();
        @(negedge clk);
        step();
        rst = 1'b1;
        iss_valid = 1'b1; iss_wr = 1'b0; iss_rs1 = 5'd9; iss_rs2 = 5'd3;
        step();
        set_idle();

        // randomized traffic
        for (int c = 0; c < 600; c++) begin
            if (!alu_valid && $urandom_range(1, 0) == 1) begin
                alu_rd = ($urandom_range(7, 0) == 0) ? 5'd0 : pick_rd(lsu_rd, lsu_valid);
                alu_data = $urandom;
                alu_valid = 1'b1;
            end
            if (!lsu_valid && $urandom_range(1, 0) == 1) begin
                lsu_rd = ($urandom_range(7, 0) == 0) ? 5'd0 : pick_rd(alu_rd, alu_valid);
                lsu_data = $urandom;
                lsu_valid = 1'b1;
            end
            iss_valid = ($urandom_range(2, 0) != 0);
            iss_wr    = ($urandom_range(3, 0) != 0);
            iss_rs1   = 5'($urandom_range(31, 0));
            iss_rs2   = 5'($urandom_range(31, 0));
            iss_rd    = 5'($urandom_range(31, 0));
            step();
            if (m_alu_acc) alu_valid = 1'b0;
            if (m_lsu_acc) lsu_valid = 1'b0;
        end

        // drain outstanding requests within a bounded number of cycles
        iss_valid = 1'b0;
        for (int c = 0; c < 20 && (alu_valid || lsu_valid); c++) begin
            step();
            if (m_alu_acc) alu_valid = 1'b0;
            if (m_lsu_acc) lsu_valid = 1'b0;
        end
        chk("drain_done", {alu_valid, lsu_valid}, 64'd0);
        set_idle();
        step();
        chk("queue_empty", exp_q.size(), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
